// File: rtl/dequant_block_writer_pkg.sv
// Shared types, frame geometry and dequantisation shift tables for the pre-IDCT block writer.
package dequant_block_writer_pkg;

  typedef enum logic [1:0] {S_DQ_IDLE, S_DQ_ACTIVE, S_DQ_FLUSH} Dequant_state_type;
  typedef enum logic [1:0] {SegY, SegU, SegV} seg_e;

  localparam logic [17:0] PRE_IDCT_Y_BASE = 18'd76800;
  localparam logic [17:0] PRE_IDCT_U_BASE = 18'd153600;
  localparam logic [17:0] PRE_IDCT_V_BASE = 18'd192000;
  localparam logic [17:0] Y_STRIDE        = 18'd320;
  localparam logic [17:0] UV_STRIDE       = 18'd160;
  localparam int unsigned Y_BLOCK_COLS    = 40;
  localparam int unsigned UV_BLOCK_COLS   = 20;
  localparam int unsigned BLOCK_ROWS      = 30;

  // Shift per diagonal d = r + c, entry 0 in the least significant 3 bits.
  localparam logic [44:0] Q0_SHIFT = {3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6,
                                      3'd6, 3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd3};
  localparam logic [44:0] Q1_SHIFT = {3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd4,
                                      3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd1, 3'd3};

  function automatic logic [2:0] dq_shift(input logic q_sel, input logic [3:0] diag);
    logic [44:0] tbl;
    tbl = q_sel ? Q1_SHIFT : Q0_SHIFT;
    return tbl[int'(diag) * 3 +: 3];
  endfunction

  function automatic logic [17:0] seg_base(input seg_e seg);
    case (seg)
      SegY:    return PRE_IDCT_Y_BASE;
      SegU:    return PRE_IDCT_U_BASE;
      default: return PRE_IDCT_V_BASE;
    endcase
  endfunction

  function automatic logic [17:0] seg_stride(input seg_e seg);
    return (seg == SegY) ? Y_STRIDE : UV_STRIDE;
  endfunction

  function automatic logic [5:0] seg_cols(input seg_e seg);
    return (seg == SegY) ? 6'(Y_BLOCK_COLS) : 6'(UV_BLOCK_COLS);
  endfunction

endpackage

// File: rtl/zigzag_lut.sv
// JPEG zigzag scan index to (row, col) position inside an 8x8 block.
module zigzag_lut (
  input  logic [5:0] idx_i,
  output logic [2:0] row_o,
  output logic [2:0] col_o
);

  // Row-major position {row, col} of each zigzag index.
  localparam logic [5:0] ZzPos [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  assign {row_o, col_o} = ZzPos[idx_i];

endmodule

// File: rtl/dequant_block_writer.sv
// Dequantises a zigzag coefficient stream and writes it row-major into the pre-IDCT SRAM region.
module dequant_block_writer
  import dequant_block_writer_pkg::*;
#(
  parameter int unsigned BlockRows = BLOCK_ROWS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        q_sel_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_coeff_i,
  output logic [17:0] sram_address_o,
  output logic [15:0] sram_write_data_o,
  output logic        sram_we_n_o,
  output logic        stripe_done_o,
  output logic        done_o
);

  Dequant_state_type state_q, state_d;
  seg_e        seg_q, seg_d;
  logic [5:0]  zz_q, zz_d;
  logic [5:0]  bx_q, bx_d;
  logic [4:0]  by_q, by_d;
  logic [17:0] row_base_q, row_base_d;
  logic [17:0] col_base_q, col_base_d;
  logic        q_sel_q, q_sel_d;

  logic        s1_valid_q, s1_uv_q, s1_row_end_q, s1_final_q;
  logic [15:0] s1_coeff_q;
  logic [2:0]  s1_r_q, s1_c_q, s1_shift_q;
  logic [17:0] s1_base_q;

  logic [17:0] addr_q;
  logic [15:0] data_q;
  logic        we_n_q, s2_row_end_q, s2_final_q, stripe_q, done_q;

  logic [2:0]  zz_row, zz_col;
  logic [3:0]  diag;
  logic        xfer, blk_end, last_bx, last_by, row_end, frame_end;
  logic [17:0] r_wide, row_off, addr_d;
  logic signed [21:0] wide;
  logic [15:0] sat;

  zigzag_lut u_zigzag_lut (
    .idx_i (zz_q),
    .row_o (zz_row),
    .col_o (zz_col)
  );

  assign in_ready_o = (state_q == S_DQ_ACTIVE);
  assign xfer       = in_valid_i & in_ready_o;
  assign diag       = {1'b0, zz_row} + {1'b0, zz_col};
  assign blk_end    = (zz_q == 6'd63);
  assign last_bx    = (bx_q == seg_cols(seg_q) - 6'd1);
  assign last_by    = (by_q == 5'(BlockRows - 1));
  assign row_end    = blk_end & last_bx;
  assign frame_end  = row_end & last_by & (seg_q == SegV);

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    zz_d       = zz_q;
    bx_d       = bx_q;
    by_d       = by_q;
    row_base_d = row_base_q;
    col_base_d = col_base_q;
    q_sel_d    = q_sel_q;
    unique case (state_q)
      S_DQ_IDLE: begin
        if (start_i) begin
          state_d    = S_DQ_ACTIVE;
          seg_d      = SegY;
          zz_d       = '0;
          bx_d       = '0;
          by_d       = '0;
          row_base_d = PRE_IDCT_Y_BASE;
          col_base_d = '0;
          q_sel_d    = q_sel_i;
        end
      end
      S_DQ_ACTIVE: begin
        if (xfer) begin
          zz_d = zz_q + 6'd1;
          if (blk_end) begin
            if (last_bx) begin
              bx_d       = '0;
              col_base_d = '0;
              if (last_by) begin
                by_d       = '0;
                seg_d      = (seg_q == SegY) ? SegU : SegV;
                row_base_d = seg_base(seg_d);
              end else begin
                by_d       = by_q + 5'd1;
                row_base_d = row_base_q + (seg_stride(seg_q) << 3);
              end
            end else begin
              bx_d       = bx_q + 6'd1;
              col_base_d = col_base_q + 18'd8;
            end
          end
          if (frame_end) state_d = S_DQ_FLUSH;
        end
      end
      S_DQ_FLUSH: state_d = S_DQ_IDLE;
      default:    state_d = S_DQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_DQ_IDLE;
      seg_q      <= SegY;
      zz_q       <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      row_base_q <= '0;
      col_base_q <= '0;
      q_sel_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      zz_q       <= zz_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      row_base_q <= row_base_d;
      col_base_q <= col_base_d;
      q_sel_q    <= q_sel_d;
    end
  end

  // Row offset r*320 or r*160 built from shifts.
  assign r_wide  = 18'(s1_r_q);
  assign row_off = s1_uv_q ? (r_wide << 7) + (r_wide << 5) : (r_wide << 8) + (r_wide << 6);
  assign addr_d  = s1_base_q + row_off + 18'(s1_c_q);

  assign wide = $signed({{6{s1_coeff_q[15]}}, s1_coeff_q}) <<< s1_shift_q;
  always_comb begin
    sat = wide[15:0];
    if (wide > 22'sd32767)       sat = 16'h7FFF;
    else if (wide < -22'sd32768) sat = 16'h8000;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_coeff_q   <= '0;
      s1_r_q       <= '0;
      s1_c_q       <= '0;
      s1_shift_q   <= '0;
      s1_base_q    <= '0;
      s1_uv_q      <= 1'b0;
      s1_row_end_q <= 1'b0;
      s1_final_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      we_n_q       <= 1'b1;
      s2_row_end_q <= 1'b0;
      s2_final_q   <= 1'b0;
      stripe_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_coeff_q   <= in_coeff_i;
        s1_r_q       <= zz_row;
        s1_c_q       <= zz_col;
        s1_shift_q   <= dq_shift(q_sel_q, diag);
        s1_base_q    <= row_base_q + col_base_q;
        s1_uv_q      <= (seg_q != SegY);
        s1_row_end_q <= row_end;
        s1_final_q   <= frame_end;
      end
      we_n_q <= ~s1_valid_q;
      if (s1_valid_q) begin
        addr_q <= addr_d;
        data_q <= sat;
      end
      s2_row_end_q <= s1_valid_q & s1_row_end_q;
      s2_final_q   <= s1_valid_q & s1_final_q;
      stripe_q     <= s2_row_end_q;
      done_q       <= s2_final_q;
    end
  end

  assign sram_address_o    = addr_q;
  assign sram_write_data_o = data_q;
  assign sram_we_n_o       = we_n_q;
  assign stripe_done_o     = stripe_q;
  assign done_o            = done_q;

endmodule

// File: doc/dequant_block_writer.md
Name: dequant_block_writer

Overview:
- Upstream feeder of the IDCT stage. Consumes a stream of quantized 8x8 coefficients in zigzag order from the lossless decoder.
- Dequantizes each coefficient with a power-of-two shift and places it in row-major position.
- Writes the whole frame (2400 blocks: 1200 Y, 600 U, 600 V) into the pre-IDCT SRAM region, 76800..230399, one 16-bit word per coefficient, in the layout the IDCT stage reads.

Parameters:
PRE_IDCT_Y_BASE, 18'd76800, Y coefficient segment base
PRE_IDCT_U_BASE, 18'd153600, U coefficient segment base
PRE_IDCT_V_BASE, 18'd192000, V coefficient segment base
Y_STRIDE, 18'd320, words per Y coefficient row
UV_STRIDE, 18'd160, words per U/V coefficient row
Y_BLOCK_COLS, 40, Y blocks per block row
UV_BLOCK_COLS, 20, U/V blocks per block row
BLOCK_ROWS, 30, block rows per segment

Ports:
Clock  input  1  system clock
Resetn  input  1  asynchronous active-low reset
Start  input  1  one-cycle pulse; begins a frame; sampled only in IDLE
Q_sel  input  1  quantization table select (0=Q0, 1=Q1); latched on accepted Start
In_valid  input  1  In_coeff valid
In_ready  output  1  block accepts a coefficient this cycle
In_coeff  input  16  signed quantized coefficient, zigzag order
SRAM_address  output  18  write address
SRAM_write_data  output  16  dequantized coefficient
SRAM_we_n  output  1  active-low write enable
Stripe_done  output  1  pulse: all blocks of one block row fully written
Done  output  1  pulse: final word of frame written

Behaviour:
- Reset: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, In_ready=0, Stripe_done=0, Done=0. All counters are 0 and the state is IDLE. Reset mid-frame abandons the frame; no further writes occur.
- States:
  - IDLE: In_ready=0. Start moves to ACTIVE and clears zz_idx (0..63), bx, by, and seg (Y/U/V).
  - ACTIVE: In_ready=1. A transfer occurs when In_valid&In_ready. When the 64th coefficient of the 2400th block is accepted, go to FLUSH.
  - FLUSH: In_ready=0. Wait one cycle for the final write, then pulse Done and return to IDLE.
- Start outside IDLE is ignored.
- Pipeline, for a transfer on edge k:
  - Stage 1 (edge k): register the coefficient. Register (r,c) from the zigzag table and register the shift.
  - Stage 2 (edge k+1): drive SRAM_address, SRAM_write_data, and SRAM_we_n=0.
  - SRAM_we_n returns to 1 on the first edge with no stage-1 valid. One write per cycle, so there is no backpressure while ACTIVE.
- Zigzag: standard JPEG order. Index 0->(0,0), 1->(0,1), 2->(1,0), 3->(2,0), 4->(1,1), 5->(0,2) ... 63->(7,7).
- Dequant: d=r+c, value = In_coeff <<< shift(d).
  - Q0 shifts by d=0..14: 3,2,3,4,5,5,6,6,6,6,6,6,6,6,6.
  - Q1 shifts by d=0..14: 3,1,1,2,3,3,4,4,5,5,5,5,5,5,5.
  - Compute in 22-bit signed, then saturate to [-32768, 32767].
- Address: base(seg) + (by*8+r)*stride(seg) + bx*8 + c.
  - Y uses Y_BLOCK_COLS; U and V use UV_BLOCK_COLS.
  - Use multiply-free increments: keep a running block-row base and add stride*8 per block row.
- Counters: zz_idx wraps 63->0 and advances bx.
  - bx wraps at the segment's block-column count and advances by.
  - by wraps at 30 and advances seg Y->U->V.
- Stripe_done: one-cycle pulse in the cycle after the stage-2 write of coefficient 63 of the last block in a block row. It fires 90 times per frame (30 per segment). On the final stripe it coincides with Done.
- Simultaneous Start and In_valid in IDLE: Start is taken and no coefficient is accepted that cycle.

Decomposition:
- Shared package (alongside the existing state typedefs) holds:
  - the Dequant_state_type enum {S_DQ_IDLE, S_DQ_ACTIVE, S_DQ_FLUSH};
  - the segment base and stride constants;
  - the two 15-entry shift tables.
- One combinational sub-module, zigzag_lut: 6-bit index in, 3-bit row and 3-bit col out.

Test Plan:
- Start with Q_sel=0, then In_coeff=5 at index 0 -> two edges later SRAM_address=76800, data=40, we_n=0.
- Indices 1 and 2 with coeff -3 and 7 under Q0 -> addr 76801 data 16'hFFF4; addr 77120 data 28.
- Q_sel=1, index 0 coeff 16'h1000 -> data 16'h7FFF (saturated). Coeff 16'hF000 -> 16'h8000.
- Stream 40 full Y blocks, then block 40 index 0 -> Stripe_done pulses once after block 39's last write; next addr=79360.
- Full frame -> block 1200 index 0 at 153600; block 1800 index 0 at 192000; last write addr 230399; Done pulse; In_ready=0 afterwards.
- Deassert Resetn mid-block with In_valid held -> outputs return to reset values at once; no writes until a new Start; new frame restarts at 76800.
